cursor_access_arbiter: RTL

- Shares one byte-wide string buffer and its single shared cursor (`pos`) between NREQ requesters.
- Each granted operation reads or writes the buffer at the cursor. The cursor can be pre-/post-incremented, pre-/post-decremented, or set, so index side effects happen exactly once per access.
- Requesters are served round-robin, one operation at a time, through a three-state sequencer.
- Sits in front of the shared string/array storage in test designs that exercise indexed access with side effects.

---
 rtl/cursor_access_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/cursor_access_arbiter.sv
// cursor_access_arbiter: round-robin shared byte buffer with a single side-effecting cursor
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   req/op/arg             per-requester request, 3-bit opcode and 8-bit argument
//   gnt                    one-hot single-cycle grant
//   rsp_valid/id/data/pos  single-cycle response carrying the cursor value after the operation
//   ld_valid/addr/data     backdoor buffer write, accepted in any state
module cursor_access_arbiter #(
    parameter int DEPTH = 16,
    parameter int NREQ  = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] op,
    input  logic [8*NREQ-1:0] arg,
    output logic [NREQ-1:0]   gnt,
    output logic              rsp_valid,
    output logic [IW-1:0]     rsp_id,
    output logic [7:0]        rsp_data,
    output logic [AW-1:0]     rsp_pos,
    input  logic              ld_valid,
    input  logic [AW-1:0]     ld_addr,
    input  logic [7:0]        ld_data
);
    localparam logic [2:0] OP_PREINC  = 3'd1;
    localparam logic [2:0] OP_POSTINC = 3'd2;
    localparam logic [2:0] OP_PREDEC  = 3'd3;
    localparam logic [2:0] OP_POSTDEC = 3'd4;
    localparam logic [2:0] OP_SET     = 3'd5;
    localparam logic [2:0] OP_WRITE   = 3'd6;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] pos, addr, new_pos;
    logic [IW-1:0] last_winner, winner, cur_id;
    logic [2:0]    cur_op;
    logic [7:0]    cur_arg, dat, rd;
    logic          found;
    int            idx;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_winner) + k) % NREQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    // Pre-ops touch the moved cursor; everything else touches the current one.
    always_comb begin
        addr    = cur_op == OP_PREINC ? pos + AW'(1) :
                  cur_op == OP_PREDEC ? pos - AW'(1) : pos;
        new_pos = (cur_op == OP_PREINC || cur_op == OP_POSTINC) ? pos + AW'(1) :
                  (cur_op == OP_PREDEC || cur_op == OP_POSTDEC) ? pos - AW'(1) :
                  cur_op == OP_SET ? cur_arg[AW-1:0] : pos;
        rd      = cur_op == OP_SET ? 8'd0 : mem[addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pos         <= '0;
            gnt         <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_data    <= '0;
            rsp_pos     <= '0;
            last_winner <= IW'(NREQ - 1);
            cur_id      <= '0;
            cur_op      <= '0;
            cur_arg     <= '0;
            dat         <= '0;
        end else begin
            gnt       <= '0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    gnt         <= NREQ'(1) << winner;
                    cur_op      <= op[3*winner +: 3];
                    cur_arg     <= arg[8*winner +: 8];
                    cur_id      <= winner;
                    last_winner <= winner;
                    state       <= EXEC;
                end
                EXEC: begin
                    dat   <= rd;
                    pos   <= new_pos;
                    state <= RESP;
                end
                RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= cur_id;
                    rsp_data  <= dat;
                    rsp_pos   <= pos;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The operation write comes last so it overrides a same-address backdoor load.
    always_ff @(posedge clk) begin
        if (ld_valid) mem[ld_addr] <= ld_data;
        if (!rst && state == EXEC && cur_op == OP_WRITE) mem[pos] <= cur_arg;
    end
endmodule
